// File: rtl/arm_pkg.sv
// Shared definitions for the ARM execute stage:
// ALU commands, forward selects and flag indices.
package arm_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cmd_legal(
    input logic [3:0] cmd
  );
    return (cmd >= EXE_MOV) &&
           (cmd <= EXE_MVN);
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU with NZCV generation.
// Subtraction runs as op1 + ~op2 + cin so C is NOT borrow.
import arm_pkg::*;

module alu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [3:0]        cmd,
  input  logic              c_in,
  input  logic              shift_carry,
  input  logic              v_in,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        nzcv_next
);

  localparam int MSB = DATA_W - 1;

  logic              w_arith;
  logic              w_cin;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;

  always_comb begin
    res     = '0;
    w_arith = 1'b0;
    w_cin   = 1'b0;
    w_b     = op2;
    unique case (cmd)
      EXE_MOV: res = op2;
      EXE_MVN: res = ~op2;
      EXE_AND: res = op1 & op2;
      EXE_ORR: res = op1 | op2;
      EXE_EOR: res = op1 ^ op2;
      EXE_ADD: w_arith = 1'b1;
      EXE_ADC: begin
        w_arith = 1'b1;
        w_cin   = c_in;
      end
      EXE_SUB: begin
        w_arith = 1'b1;
        w_b     = ~op2;
        w_cin   = 1'b1;
      end
      EXE_SBC: begin
        w_arith = 1'b1;
        w_b     = ~op2;
        w_cin   = c_in;
      end
      default: res = '0;
    endcase
    w_sum = {1'b0, op1}
          + {1'b0, w_b}
          + {{DATA_W{1'b0}}, w_cin};
    if (w_arith) res = w_sum[MSB:0];
  end

  always_comb begin
    nzcv_next         = '0;
    nzcv_next[FLAG_N] = res[MSB];
    nzcv_next[FLAG_Z] = ~|res;
    if (w_arith) begin
      nzcv_next[FLAG_C] = w_sum[DATA_W];
      // same-sign operands, different-sign result
      nzcv_next[FLAG_V] = (op1[MSB] == w_b[MSB]) &&
                          (res[MSB] != op1[MSB]);
    end else begin
      nzcv_next[FLAG_C] = shift_carry;
      nzcv_next[FLAG_V] = v_in;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, ALU, NZCV status,
// branch target and the EXE/MEM pipeline register.
import arm_pkg::*;

module exe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int IMM_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              valid_in,
  input  logic [3:0]        exe_cmd,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic              shift_carry,
  input  logic [DATA_W-1:0] rm_val,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [IMM_W-1:0]  imm24,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_fwd,
  input  logic [DATA_W-1:0] wb_fwd,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_W-1:0]  dest_out
);

  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_st;
  logic [DATA_W-1:0] w_res;
  logic [3:0]        w_nzcv;
  logic [DATA_W-1:0] w_off;
  logic              w_go;

  logic [3:0]        r_status;
  logic              r_wb;
  logic              r_mr;
  logic              r_mw;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_st;
  logic [REG_W-1:0]  r_dest;

  always_comb begin
    case (sel_src1)
      FWD_MEM: w_op1 = mem_fwd;
      FWD_WB:  w_op1 = wb_fwd;
      default: w_op1 = val1;
    endcase
  end

  always_comb begin
    case (sel_src2)
      FWD_MEM: w_st = mem_fwd;
      FWD_WB:  w_st = wb_fwd;
      default: w_st = rm_val;
    endcase
  end

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op1        (w_op1),
    .op2        (val2),
    .cmd        (exe_cmd),
    .c_in       (r_status[FLAG_C]),
    .shift_carry(shift_carry),
    .v_in       (r_status[FLAG_V]),
    .res        (w_res),
    .nzcv_next  (w_nzcv)
  );

  assign w_go = valid_in & ~freeze;

  assign w_off = {{(DATA_W-IMM_W){imm24[IMM_W-1]}},
                  imm24};
  assign branch_addr  = pc_in + (w_off << 2);
  assign branch_taken = b_in & w_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= 4'b0000;
    end else if (s_in & w_go &
                 cmd_legal(exe_cmd)) begin
      r_status <= w_nzcv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb   <= 1'b0;
      r_mr   <= 1'b0;
      r_mw   <= 1'b0;
      r_res  <= '0;
      r_st   <= '0;
      r_dest <= '0;
    end else if (!freeze) begin
      r_wb   <= wb_en_in & valid_in;
      r_mr   <= mem_r_en_in & valid_in;
      r_mw   <= mem_w_en_in & valid_in;
      r_res  <= w_res;
      r_st   <= w_st;
      r_dest <= dest_in;
    end
  end

  assign status       = r_status;
  assign wb_en_out    = r_wb;
  assign mem_r_en_out = r_mr;
  assign mem_w_en_out = r_mw;
  assign alu_res      = r_res;
  assign st_val       = r_st;
  assign dest_out     = r_dest;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an
// arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, valid_in;
  logic [3:0]  exe_cmd;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in;
  logic        b_in, s_in, shift_carry;
  logic [31:0] pc_in, val1, val2, rm_val;
  logic [3:0]  dest_in;
  logic [23:0] imm24;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd, wb_fwd;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  m_status;
  logic        m_wb, m_mr, m_mw, m_dv;
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .valid_in(valid_in), .exe_cmd(exe_cmd),
    .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in),
    .wb_en_in(wb_en_in), .b_in(b_in),
    .s_in(s_in), .pc_in(pc_in), .val1(val1),
    .val2(val2), .shift_carry(shift_carry),
    .rm_val(rm_val), .dest_in(dest_in),
    .imm24(imm24), .sel_src1(sel_src1),
    .sel_src2(sel_src2), .mem_fwd(mem_fwd),
    .wb_fwd(wb_fwd),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .status(status), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out),
    .alu_res(alu_res), .st_val(st_val),
    .dest_out(dest_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic void ref_alu(
    input  logic [3:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  st,
    input  logic        sc,
    output logic [31:0] r,
    output logic [3:0]  f,
    output bit          ok
  );
    longint ua, sa, cy;
    bit cf, vf;
    cy = longint'(st[1]);
    ok = 1; cf = sc; vf = st[0]; r = '0;
    ua = 0; sa = 0;
    case (c)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        if (c == 4'd2) cy = 0;
        ua = longint'(a) + longint'(b) + cy;
        sa = longint'($signed(a))
           + longint'($signed(b)) + cy;
        r  = ua[31:0];
        cf = ua > 64'sh0FFFF_FFFF;
        vf = sa > 64'sd2147483647 ||
             sa < -64'sd2147483648;
      end
      4'd4, 4'd5: begin
        cy = (c == 4'd4) ? 0 : 1 - cy;
        ua = longint'(a) - longint'(b) - cy;
        sa = longint'($signed(a))
           - longint'($signed(b)) - cy;
        r  = ua[31:0];
        cf = ua >= 0;
        vf = sa > 64'sd2147483647 ||
             sa < -64'sd2147483648;
      end
      default: ok = 0;
    endcase
    f = {r[31], r == 32'd0, cf, vf};
  endfunction

  function automatic logic [31:0] pick(
    input logic [1:0]  s,
    input logic [31:0] id
  );
    if (s == 2'b01) return mem_fwd;
    if (s == 2'b10) return wb_fwd;
    return id;
  endfunction

  task automatic model_edge();
    logic [31:0] r;
    logic [3:0]  f;
    bit ok;
    if (rst) begin
      m_status = 0; m_wb = 0; m_mr = 0; m_mw = 0;
      m_res = 0; m_st = 0; m_dest = 0; m_dv = 1;
    end else if (!freeze) begin
      ref_alu(exe_cmd, pick(sel_src1, val1), val2,
              m_status, shift_carry, r, f, ok);
      if (s_in && valid_in && ok) m_status = f;
      m_wb   = wb_en_in & valid_in;
      m_mr   = mem_r_en_in & valid_in;
      m_mw   = mem_w_en_in & valid_in;
      m_res  = r;
      m_st   = pick(sel_src2, rm_val);
      m_dest = dest_in;
      m_dv   = valid_in;
    end
  endtask

  task automatic step();
    logic [31:0] ea;
    #1;
    ea = pc_in + 32'(int'($signed(imm24)) * 4);
    chk("br_taken", 32'(branch_taken),
        32'(b_in & valid_in & ~freeze));
    chk("br_addr", branch_addr, ea);
    @(posedge clk);
    model_edge();
    #1;
    chk("status", 32'(status), 32'(m_status));
    chk("wb_en", 32'(wb_en_out), 32'(m_wb));
    chk("mem_r", 32'(mem_r_en_out), 32'(m_mr));
    chk("mem_w", 32'(mem_w_en_out), 32'(m_mw));
    if (m_dv) begin
      chk("alu_res", alu_res, m_res);
      chk("st_val", st_val, m_st);
      chk("dest", 32'(dest_out), 32'(m_dest));
    end
  endtask

  task automatic idle();
    rst = 0; freeze = 0; valid_in = 1;
    exe_cmd = 4'd2; mem_r_en_in = 0;
    mem_w_en_in = 0; wb_en_in = 1; b_in = 0;
    s_in = 0; shift_carry = 0; pc_in = 0;
    val1 = 0; val2 = 0; rm_val = 0; dest_in = 1;
    imm24 = 0; sel_src1 = 0; sel_src2 = 0;
    mem_fwd = 0; wb_fwd = 0;
  endtask

  logic [3:0] held;

  initial begin
    idle();
    rst = 1; freeze = 1; s_in = 1;
    val1 = 32'h1234; val2 = 32'h55;
    step();
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_res", alu_res, 32'd0);

    idle();
    s_in = 1; val1 = 32'h7FFF_FFFF; val2 = 32'd1;
    step();
    chk("add_ovf_res", alu_res, 32'h8000_0000);
    chk("add_ovf_nzcv", 32'(status), 32'b1001);

    idle();
    exe_cmd = 4'd4; s_in = 1; wb_en_in = 0;
    val1 = 32'd5; val2 = 32'd5;
    step();
    chk("cmp_nzcv", 32'(status), 32'b0110);
    chk("cmp_wb", 32'(wb_en_out), 32'd0);
    idle();
    exe_cmd = 4'd3; val1 = 32'd1; val2 = 32'd1;
    step();
    chk("adc_res", alu_res, 32'd3);

    idle();
    b_in = 1; pc_in = 32'h100; imm24 = 24'hFFFFFE;
    #1;
    chk("br_t", 32'(branch_taken), 32'd1);
    chk("br_a", branch_addr, 32'h0F8);
    freeze = 1;
    #1;
    chk("br_frz", 32'(branch_taken), 32'd0);
    step();

    idle();
    held = status;
    exe_cmd = 4'd2; s_in = 1; freeze = 1;
    val1 = 32'hFFFF_FFFF; val2 = 32'd1;
    repeat (3) begin
      step();
      chk("frz_status", 32'(status), 32'(held));
    end
    freeze = 0;
    step();
    chk("rel_nzcv", 32'(status), 32'b0110);
    chk("rel_res", alu_res, 32'd0);
    valid_in = 0;
    step();
    chk("no_dbl", 32'(status), 32'b0110);

    idle();
    sel_src1 = 2'b01; mem_fwd = 32'h10;
    sel_src2 = 2'b10; wb_fwd = 32'hAB;
    val2 = 32'h8; mem_w_en_in = 1; wb_en_in = 0;
    step();
    chk("fwd_addr", alu_res, 32'h18);
    chk("fwd_st", st_val, 32'hAB);

    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      freeze      = ($urandom_range(0, 4) == 0);
      valid_in    = ($urandom_range(0, 4) != 0);
      exe_cmd     = 4'($urandom_range(0, 15));
      mem_r_en_in = 1'($urandom);
      mem_w_en_in = 1'($urandom);
      wb_en_in    = 1'($urandom);
      b_in        = 1'($urandom);
      s_in        = 1'($urandom);
      shift_carry = 1'($urandom);
      pc_in       = $urandom;
      val1        = ($urandom_range(0, 3) == 0) ?
                    32'h7FFF_FFFF : $urandom;
      val2        = ($urandom_range(0, 3) == 0) ?
                    val1 : $urandom;
      rm_val      = $urandom;
      dest_in     = 4'($urandom);
      imm24       = 24'($urandom);
      sel_src1    = 2'($urandom);
      sel_src2    = 2'($urandom);
      mem_fwd     = $urandom;
      wb_fwd      = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
